bk_adder_pipe: RTL
==================

Name: bk_adder_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed 12-bit Brent-Kung adder netlist.
- Adds width/depth generics, carry-in, an add/subtract mode and a valid/ready handshake with full backpressure.
- Keeps the interleaved operand packing: bit 2i = a[i], bit 2i+1 = b[i].
- Sits between operand-fetch logic and any WIDTH+1-bit result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 12: operand width in bits; power of two not required; legal range 2..64.
- STAGES, 2: number of pipeline register ranks, equal to the latency in cycles; legal range 1..BK_LEVELS(WIDTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  2*WIDTH  interleaved operands: bit 2i = a[i], bit 2i+1 = b[i].
- in_cin  in  1  carry-in.
- in_sub  in  1  1 = compute a - b - ~cin; in_cin must be 1 for a true a-b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH+1  bit WIDTH is carry-out (for subtract, 1 = no borrow).

Behaviour:
- Beat transfer: a beat is accepted when in_valid & in_ready.
- Result transfer: a result leaves when out_valid & out_ready.
- Operand formation: b_eff = in_sub ? ~b : b.
- Bit generate/propagate: g = a & b_eff, p = a ^ b_eff.
- Carry-in handling: cin is folded in as the generate of a virtual bit -1.
- Prefix tree: Brent-Kung with BK_LEVELS = 2*ceil(log2 WIDTH) - 1 prefix levels, up-sweep then down-sweep.
- Result: sum[i] = p[i] ^ c[i]; out_sum[WIDTH] = c[WIDTH]. All arithmetic is modulo 2^(WIDTH+1).
- Register placement: rank k sits after prefix level floor(k*BK_LEVELS/STAGES). The last rank always registers out_sum.
- Latency: exactly STAGES cycles from acceptance to out_valid when there is no backpressure. Throughput is 1 beat per cycle.
- Stage advance: each rank has its own valid bit. Rank k loads when it is empty or rank k+1 loads/drains that cycle.
- in_ready = ~v[0] | rank 0 advancing. This is combinational from out_ready, with no combinational path from in_valid.
- Stalled ranks hold their data and valid bits unchanged. Bubbles compress.
- When the pipeline is full and out_ready=0, in_ready=0.
- Simultaneous accept and drain on a full pipe: both occur, and occupancy is unchanged.
- Reset values: all valid bits 0, out_valid=0, out_sum=0, in_ready=1 on the first cycle after reset.
- Reset mid-operation: in-flight beats are discarded with no output. Data registers need not be cleared except out_sum.
- Outputs must be stable while out_valid & ~out_ready.

Optional Feature:
- Macro: BK_ADDER_STATUS_EN.
- Defined: adds outputs out_ovf (1 bit) and out_zero (1 bit), pipelined with out_sum and reset to 0.
  - out_ovf = signed two's-complement overflow = c[WIDTH] ^ c[WIDTH-1].
  - out_zero = (out_sum[WIDTH-1:0] == 0).
- Undefined: these ports and their registers do not exist; everything else is identical.

Decomposition:
- Package bk_adder_pkg holds:
  - function bk_levels(width);
  - function bk_rank_level(k, stages, levels);
  - typedef bk_gp_t {g, p};
  - pack/unpack helpers for the interleaved bus.
- Sub-module bk_prefix_level: one combinational Brent-Kung level parameterised by WIDTH and level index.
  - Instantiated BK_LEVELS times.
  - Ranks are inserted between instances by generate.

Test Plan:
- Max-add: WIDTH=12, STAGES=2, a=0xFFF, b=0x001, cin=0, sub=0 -> out_sum=0x1000 exactly 2 cycles after accept.
- Subtract: a=5, b=7, sub=1, cin=1 -> out_sum=0x0FFE (bit12=0, borrow). Then a=7, b=5 -> 0x1002.
- Backpressure: out_ready=0 while streaming beats 1,2,3.
  - in_ready drops after 2 accepted beats.
  - out_sum holds beat 1's result.
  - Releasing out_ready yields beats 1,2,3 in order, none lost or duplicated.
- Full-throughput stream: 256 random beats, out_ready=1, across WIDTH in {2,12,13,32} and STAGES in {1, BK_LEVELS+1}.
  - Every result equals the reference a+b_eff+cin.
  - out_valid stays continuous after the fill.
- Reset mid-flight: assert rst for 1 cycle with 2 beats in the pipe -> out_valid=0 next cycle, those beats never appear, in_ready=1.
- With BK_ADDER_STATUS_EN, WIDTH=12:
  - a=0x7FF, b=0x001 -> out_ovf=1, out_zero=0.
  - a=0x800, b=0x800 -> out_ovf=1, out_zero=1, out_sum=0x1000.

Source files
------------

// File: rtl/bk_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Brent-Kung adder.
package bk_adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } bk_gp_t;

    function automatic int bk_levels(input int width);
        return 2 * $clog2(width) - 1;
    endfunction

    function automatic int bk_rank_level(input int k, input int stages, input int levels);
        return (k * levels) / stages;
    endfunction

    // 0-based rank registered in front of prefix level `level`, or -1 if that boundary is wired through.
    function automatic int bk_rank_at(input int level, input int stages, input int levels);
        int rank = -1;
        for (int k = 1; k < stages; k++)
            if (bk_rank_level(k, stages, levels) == level) rank = k - 1;
        return rank;
    endfunction

    function automatic int bk_a_bit(input int i);
        return 2 * i;
    endfunction

    function automatic int bk_b_bit(input int i);
        return 2 * i + 1;
    endfunction

endpackage

// File: rtl/bk_prefix_level.sv
// One combinational Brent-Kung prefix level: up-sweep for LEVEL < log2(WIDTH), down-sweep after.
module bk_prefix_level
    import bk_adder_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int LEVEL = 0
) (
    input  bk_gp_t [WIDTH-1:0] gp_in,
    output bk_gp_t [WIDTH-1:0] gp_out
);

    localparam int LOG2W = $clog2(WIDTH);
    localparam bit UP    = LEVEL < LOG2W;
    localparam int SPAN  = UP ? (1 << LEVEL) : (1 << (2 * LOG2W - 2 - LEVEL));

    for (genvar i = 0; i < WIDTH; i++) begin : g_node
        // Up-sweep merges aligned blocks; down-sweep finishes odd multiples of SPAN from a complete prefix.
        localparam bit ACTIVE = UP ? ((i + 1) % (2 * SPAN) == 0)
                                   : (((i + 1) % (2 * SPAN) == SPAN) && (i >= 2 * SPAN));
        if (ACTIVE) begin : g_op
            assign gp_out[i].g = gp_in[i].g | (gp_in[i].p & gp_in[i-SPAN].g);
            assign gp_out[i].p = gp_in[i].p & gp_in[i-SPAN].p;
        end else begin : g_thru
            assign gp_out[i] = gp_in[i];
        end
    end

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with a valid/ready handshake and full backpressure.
// Define BK_ADDER_STATUS_EN to add the registered out_ovf / out_zero status outputs.
module bk_adder_pipe
    import bk_adder_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_data,
    input  logic               in_cin,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     out_sum
`ifdef BK_ADDER_STATUS_EN
    ,
    output logic               out_ovf,
    output logic               out_zero
`endif
);

    localparam int LEVELS = bk_levels(WIDTH);

    logic [STAGES-1:0] v, v_next, adv;

    for (genvar r = 0; r < STAGES; r++) begin : g_ctl
        // A rank may load when it, or any rank downstream of it, has room this cycle.
        assign adv[r] = out_ready | ~(&v[STAGES-1:r]);
        if (r == 0) begin : g_head
            assign v_next[r] = adv[r] ? in_valid : v[r];
        end else begin : g_body
            assign v_next[r] = adv[r] ? v[r-1] : v[r];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];

    // NOTE: state uses non-blocking assignments so each rank sees its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) v <= '0;
        else     v <= v_next;
    end

    bk_gp_t [WIDTH-1:0] gp_stage  [LEVELS+1];
    logic   [WIDTH-1:0] p_stage   [LEVELS+1];
    logic               cin_stage [LEVELS+1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_form
        logic a, b_eff;
        assign a             = in_data[bk_a_bit(i)];
        assign b_eff         = in_data[bk_b_bit(i)] ^ in_sub;
        assign p_stage[0][i] = a ^ b_eff;
        if (i == 0) begin : g_fold
            // Carry-in is the generate of a virtual bit -1 (propagate 0), merged into bit 0 up front.
            assign gp_stage[0][i] = '{g: (a & b_eff) | ((a ^ b_eff) & in_cin), p: 1'b0};
        end else begin : g_bit
            assign gp_stage[0][i] = '{g: a & b_eff, p: a ^ b_eff};
        end
    end
    assign cin_stage[0] = in_cin;

    for (genvar m = 0; m < LEVELS; m++) begin : g_level
        localparam int RANK = bk_rank_at(m, STAGES, LEVELS);
        bk_gp_t [WIDTH-1:0] gp_d;
        logic   [WIDTH-1:0] p_d;
        logic               cin_d;
        if (RANK >= 0) begin : g_rank
            // NOTE: datapath ranks carry no reset; the valid bits alone decide what is live.
            always_ff @(posedge clk) begin
                if (adv[RANK]) begin
                    gp_d  <= gp_stage[m];
                    p_d   <= p_stage[m];
                    cin_d <= cin_stage[m];
                end
            end
        end else begin : g_wire
            assign gp_d  = gp_stage[m];
            assign p_d   = p_stage[m];
            assign cin_d = cin_stage[m];
        end
        bk_prefix_level #(.WIDTH(WIDTH), .LEVEL(m)) u_level (
            .gp_in  (gp_d),
            .gp_out (gp_stage[m+1])
        );
        assign p_stage[m+1]   = p_d;
        assign cin_stage[m+1] = cin_d;
    end

    logic [WIDTH-1:0] grp_g;
    logic [WIDTH-1:0] unused_grp_p;
    logic [WIDTH:0]   carry;
    logic [WIDTH:0]   sum;

    for (genvar i = 0; i < WIDTH; i++) begin : g_tap
        assign grp_g[i]        = gp_stage[LEVELS][i].g;
        assign unused_grp_p[i] = gp_stage[LEVELS][i].p;
    end

    assign carry = {grp_g, cin_stage[LEVELS]};
    assign sum   = {carry[WIDTH], p_stage[LEVELS] ^ carry[WIDTH-1:0]};

    always_ff @(posedge clk) begin
        if (rst)                out_sum <= '0;
        else if (adv[STAGES-1]) out_sum <= sum;
    end

`ifdef BK_ADDER_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
        end else if (adv[STAGES-1]) begin
            out_ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
            out_zero <= ~|sum[WIDTH-1:0];
        end
    end
`endif

endmodule
